// File: rtl/mmio_pwm_led_pkg.sv
// Shared definitions for the memory-mapped PWM LED block: register map,
// RV32I load/store size codes, duty record and access decode helpers.
package mmio_pwm_led_pkg;

  // Word-aligned register addresses at the top of the address space
  localparam logic [31:0] ADDR_LEDS   = 32'hFFFF_FFFC;
  localparam logic [31:0] ADDR_MILLIS = 32'hFFFF_FFF8;
  localparam logic [31:0] ADDR_MICROS = 32'hFFFF_FFF4;

  // RV32I funct3 codes for stores
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // RV32I funct3 codes for loads
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Four-byte duty record, laid out exactly as the LEDS register word
  typedef struct packed {
    logic [7:0] led;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } duty_t;

  // Register selected by the current address
  typedef enum logic [1:0] {
    REG_NONE   = 2'b00,
    REG_MICROS = 2'b01,
    REG_MILLIS = 2'b10,
    REG_LEDS   = 2'b11
  } reg_sel_e;

  // Byte addresses 0xFFFFFFF4..0xFFFFFFFF belong to this block
  function automatic logic addr_hit(input logic [31:0] addr);
    return (addr[31:4] == 28'hFFF_FFFF) && (addr[3:2] != 2'b00);
  endfunction

  // Byte-lane enables for a store; misaligned or unknown sizes give no lanes
  function automatic logic [3:0] store_lanes(input logic [2:0] f3,
                                             input logic [1:0] lo);
    logic [3:0] be;
    be = 4'b0000;
    case (f3)
      F3_SB: be = 4'b0001 << lo;
      F3_SH: if (!lo[0]) be = lo[1] ? 4'b1100 : 4'b0011;
      F3_SW: if (lo == 2'b00) be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Right-align and extend load data; misaligned or illegal sizes read 0
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lo);
    logic [31:0] sh;
    logic [31:0] res;
    sh  = word >> {lo, 3'b000};
    res = 32'h0;
    case (f3)
      F3_LB:  res = {{24{sh[7]}}, sh[7:0]};
      F3_LBU: res = {24'h0, sh[7:0]};
      F3_LH:  if (!lo[0]) res = {{16{sh[15]}}, sh[15:0]};
      F3_LHU: if (!lo[0]) res = {16'h0, sh[15:0]};
      F3_LW:  if (lo == 2'b00) res = word;
      default: res = 32'h0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mmio_pwm_led_pwm_channel.sv
// One PWM output: compares the shared counter with a duty value and
// registers the result so the pin is glitch-free.
module pwm_channel #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] cnt_i,
  input  logic [7:0]          duty_i,
  output logic                pwm_o
);

  // Compare width wide enough for both the counter and the 8-bit duty
  localparam int unsigned CW = (PWM_BITS > 8) ? PWM_BITS : 8;

  logic pwm_d;
  logic pwm_q;

  // High while the counter is below the duty; duty 0 never drives high
  always_comb begin
    pwm_d = (CW'(cnt_i) < CW'(duty_i));
  end

  // Output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/mmio_pwm_led.sv
// Memory-mapped LED PWM controller with free-running millisecond and
// microsecond timers, sitting at the top of the data address space.
module mmio_pwm_led
  import mmio_pwm_led_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 12000000,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  funct3,
  input  logic        dmem_wren,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_data_in,
  output logic [31:0] dmem_data_out,
  output logic        hit,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  // Prescaler divide ratios, clamped to 1 for very slow clocks
  localparam int unsigned US_DIV_RAW = CLK_HZ / 1000000;
  localparam int unsigned MS_DIV_RAW = CLK_HZ / 1000;
  localparam int unsigned US_DIV     = (US_DIV_RAW == 0) ? 1 : US_DIV_RAW;
  localparam int unsigned MS_DIV     = (MS_DIV_RAW == 0) ? 1 : MS_DIV_RAW;
  localparam int unsigned US_W       = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int unsigned MS_W       = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

  duty_t               leds_q,   leds_d;
  duty_t               shadow_q, shadow_d;
  logic [PWM_BITS-1:0] cnt_q,    cnt_d;
  logic [US_W-1:0]     us_pre_q, us_pre_d;
  logic [MS_W-1:0]     ms_pre_q, ms_pre_d;
  logic [31:0]         micros_q, micros_d;
  logic [31:0]         millis_q, millis_d;
  logic [31:0]         rdata_q,  rdata_d;

  reg_sel_e            sel_c;
  logic [3:0]          be_c;
  logic [31:0]         wdata_c;
  logic [31:0]         rword_c;
  logic                wrap_c;
  logic                us_tick_c;
  logic                ms_tick_c;

  assign hit = addr_hit(dmem_address);

  // Decode which word register the address points at
  always_comb begin
    sel_c = REG_NONE;
    if (hit) begin
      if (dmem_address[31:2] == ADDR_LEDS[31:2]) begin
        sel_c = REG_LEDS;
      end else if (dmem_address[31:2] == ADDR_MILLIS[31:2]) begin
        sel_c = REG_MILLIS;
      end else if (dmem_address[31:2] == ADDR_MICROS[31:2]) begin
        sel_c = REG_MICROS;
      end
    end
  end

  // LEDS byte-lane write; the timers are read-only and ignore stores
  always_comb begin
    leds_d  = leds_q;
    be_c    = 4'b0000;
    wdata_c = dmem_data_in << {dmem_address[1:0], 3'b000};
    if (dmem_wren && (sel_c == REG_LEDS)) begin
      be_c = store_lanes(funct3, dmem_address[1:0]);
    end
    for (int i = 0; i < 4; i++) begin
      if (be_c[i]) begin
        leds_d[8*i +: 8] = wdata_c[8*i +: 8];
      end
    end
  end

  // Load path reads current (pre-write) register contents
  always_comb begin
    rword_c = 32'h0;
    case (sel_c)
      REG_LEDS:   rword_c = leds_q;
      REG_MILLIS: rword_c = millis_q;
      REG_MICROS: rword_c = micros_q;
      default:    rword_c = 32'h0;
    endcase
    rdata_d = (sel_c == REG_NONE) ? 32'h0
                                  : load_extend(rword_c, funct3, dmem_address[1:0]);
  end

  // Shared PWM counter; duty is latched only at the period boundary
  always_comb begin
    wrap_c   = (cnt_q == {PWM_BITS{1'b1}});
    cnt_d    = cnt_q + PWM_BITS'(1);
    shadow_d = wrap_c ? leds_q : shadow_q;
  end

  // Independent microsecond and millisecond prescalers and counters
  always_comb begin
    us_tick_c = (us_pre_q == US_W'(US_DIV - 1));
    ms_tick_c = (ms_pre_q == MS_W'(MS_DIV - 1));
    us_pre_d  = us_tick_c ? '0 : us_pre_q + US_W'(1);
    ms_pre_d  = ms_tick_c ? '0 : ms_pre_q + MS_W'(1);
    micros_d  = us_tick_c ? micros_q + 32'd1 : micros_q;
    millis_d  = ms_tick_c ? millis_q + 32'd1 : millis_q;
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds_q   <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      us_pre_q <= '0;
      ms_pre_q <= '0;
      micros_q <= 32'h0;
      millis_q <= 32'h0;
      rdata_q  <= 32'h0;
    end else begin
      leds_q   <= leds_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      us_pre_q <= us_pre_d;
      ms_pre_q <= ms_pre_d;
      micros_q <= micros_d;
      millis_q <= millis_d;
      rdata_q  <= rdata_d;
    end
  end

  assign dmem_data_out = rdata_q;

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_led (
    .clk    (clk),
    .reset  (reset),
    .cnt_i  (cnt_q),
    .duty_i (shadow_q.led),
    .pwm_o  (led)
  );

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_red (
    .clk    (clk),
    .reset  (reset),
    .cnt_i  (cnt_q),
    .duty_i (shadow_q.red),
    .pwm_o  (red)
  );

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_green (
    .clk    (clk),
    .reset  (reset),
    .cnt_i  (cnt_q),
    .duty_i (shadow_q.green),
    .pwm_o  (green)
  );

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_blue (
    .clk    (clk),
    .reset  (reset),
    .cnt_i  (cnt_q),
    .duty_i (shadow_q.blue),
    .pwm_o  (blue)
  );

endmodule

// File: tb/tb_mmio_pwm_led.sv
// Directed bench for mmio_pwm_led: register access vectors, PWM duty
// timing, timer rates and asynchronous reset behaviour.
module tb_mmio_pwm_led;

  localparam logic [31:0] A_LEDS   = 32'hFFFF_FFFC;
  localparam logic [31:0] A_MILLIS = 32'hFFFF_FFF8;
  localparam logic [31:0] A_MICROS = 32'hFFFF_FFF4;
  localparam int NV = 28;

  typedef struct {
    logic        wren;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_hit;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [2:0]  funct3;
  logic        dmem_wren;
  logic [31:0] dmem_address;
  logic [31:0] dmem_data_in;
  logic [31:0] dmem_data_out;
  logic        hit;
  logic        led, red, green, blue;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] pwm_m;
  vec_t vecs [NV];

  mmio_pwm_led #(.CLK_HZ(12000000), .PWM_BITS(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .funct3        (funct3),
    .dmem_wren     (dmem_wren),
    .dmem_address  (dmem_address),
    .dmem_data_in  (dmem_data_in),
    .dmem_data_out (dmem_data_out),
    .hit           (hit),
    .led           (led),
    .red           (red),
    .green         (green),
    .blue          (blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected PWM counter phase: cleared by reset, +1 every clock
  always @(posedge clk or posedge reset) begin
    if (reset) pwm_m <= 8'h00;
    else       pwm_m <= pwm_m + 8'h01;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // One bus cycle: drive, sample hit, clock, sample registered read data
  task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic h);
    dmem_wren    = wr;
    funct3       = f3;
    dmem_address = a;
    dmem_data_in = d;
    #1 h = hit;
    @(posedge clk);
    #1;
    rd = dmem_data_out;
    dmem_wren = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        h;
    int          n, hi_led, hi_red, hi_green, hi_blue;

    vecs[0]  = '{1'b0, 3'b010, A_LEDS,        32'h0,        32'h0000_0000, 1'b1};
    vecs[1]  = '{1'b1, 3'b000, 32'hFFFF_FFFD, 32'h80,       32'h0000_0000, 1'b1};
    vecs[2]  = '{1'b0, 3'b010, A_LEDS,        32'h0,        32'h0000_8000, 1'b1};
    vecs[3]  = '{1'b0, 3'b000, 32'hFFFF_FFFD, 32'h0,        32'hFFFF_FF80, 1'b1};
    vecs[4]  = '{1'b0, 3'b100, 32'hFFFF_FFFD, 32'h0,        32'h0000_0080, 1'b1};
    vecs[5]  = '{1'b0, 3'b001, A_LEDS,        32'h0,        32'hFFFF_8000, 1'b1};
    vecs[6]  = '{1'b0, 3'b101, A_LEDS,        32'h0,        32'h0000_8000, 1'b1};
    vecs[7]  = '{1'b1, 3'b001, 32'hFFFF_FFFD, 32'h1234,     32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b0, 3'b010, A_LEDS,        32'h0,        32'h0000_8000, 1'b1};
    vecs[9]  = '{1'b1, 3'b010, A_MILLIS,      32'h5555,     32'h0000_0000, 1'b1};
    vecs[10] = '{1'b0, 3'b010, A_MILLIS,      32'h0,        32'h0000_0000, 1'b1};
    vecs[11] = '{1'b0, 3'b010, 32'h0000_1000, 32'h0,        32'h0000_0000, 1'b0};
    vecs[12] = '{1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0,        32'h0000_0000, 1'b1};
    vecs[13] = '{1'b1, 3'b011, A_LEDS,        32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[14] = '{1'b0, 3'b010, A_LEDS,        32'h0,        32'h0000_8000, 1'b1};
    vecs[15] = '{1'b1, 3'b001, 32'hFFFF_FFFE, 32'hABCD,     32'h0000_0000, 1'b1};
    vecs[16] = '{1'b0, 3'b010, A_LEDS,        32'h0,        32'hABCD_8000, 1'b1};
    vecs[17] = '{1'b0, 3'b001, 32'hFFFF_FFFE, 32'h0,        32'hFFFF_ABCD, 1'b1};
    vecs[18] = '{1'b0, 3'b101, 32'hFFFF_FFFE, 32'h0,        32'h0000_ABCD, 1'b1};
    vecs[19] = '{1'b1, 3'b000, A_LEDS,        32'hFFFF_FF12, 32'h0000_0000, 1'b1};
    vecs[20] = '{1'b0, 3'b010, A_LEDS,        32'h0,        32'hABCD_8012, 1'b1};
    vecs[21] = '{1'b1, 3'b010, A_LEDS,        32'hFFFF_0000, 32'hABCD_8012, 1'b1};
    vecs[22] = '{1'b0, 3'b010, A_LEDS,        32'h0,        32'hFFFF_0000, 1'b1};
    vecs[23] = '{1'b0, 3'b010, 32'hFFFF_FFF0, 32'h0,        32'h0000_0000, 1'b0};
    vecs[24] = '{1'b0, 3'b000, 32'hFFFF_FFFF, 32'h0,        32'hFFFF_FFFF, 1'b1};
    vecs[25] = '{1'b1, 3'b010, 32'h0000_1000, 32'h1234_5678, 32'h0000_0000, 1'b0};
    vecs[26] = '{1'b0, 3'b010, A_LEDS,        32'h0,        32'hFFFF_0000, 1'b1};
    vecs[27] = '{1'b0, 3'b110, A_LEDS,        32'h0,        32'h0000_0000, 1'b1};

    reset = 1'b0; dmem_wren = 1'b0; funct3 = 3'b010;
    dmem_address = 32'h0; dmem_data_in = 32'h0;
    #2 reset = 1'b1;
    #1;
    check("reset_rdata", dmem_data_out, 32'h0);
    check("reset_pwm_outs", 32'({led, red, green, blue}), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Register access vectors
    for (int i = 0; i < NV; i++) begin
      access(vecs[i].wren, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, h);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_hit", i), 32'(h), 32'(vecs[i].exp_hit));
    end

    // LEDS = FFFF0000: led/red 255 of 256, green/blue never
    repeat (512) @(posedge clk);
    #1;
    hi_led = 0; hi_red = 0; hi_green = 0; hi_blue = 0;
    for (int j = 0; j < 256; j++) begin
      hi_led += int'(led); hi_red += int'(red);
      hi_green += int'(green); hi_blue += int'(blue);
      @(posedge clk); #1;
    end
    check("ff_led_high", 32'(hi_led), 32'd255);
    check("ff_red_high", 32'(hi_red), 32'd255);
    check("ff_green_high", 32'(hi_green), 32'd0);
    check("ff_blue_high", 32'(hi_blue), 32'd0);

    // Duty 0x40 written at counter 0x10 takes effect only after wrap
    for (int i = 0; i < 300 && pwm_m != 8'h10; i++) begin
      @(posedge clk); #1;
    end
    check("sync_cnt10", 32'(pwm_m), 32'h10);
    access(1'b1, 3'b010, A_LEDS, 32'h4000_0000, rd, h);
    n = 0; hi_led = 0; hi_red = 0;
    while (pwm_m != 8'h00 && n < 400) begin
      hi_led += int'(led); hi_red += int'(red);
      n++;
      @(posedge clk); #1;
    end
    check("prewrap_cycles", 32'(n), 32'd239);
    check("prewrap_led_high", 32'(hi_led), 32'd239);
    check("prewrap_red_high", 32'(hi_red), 32'd239);
    hi_led = 0; hi_red = 0; hi_green = 0;
    for (int j = 0; j < 256; j++) begin
      hi_led += int'(led); hi_red += int'(red); hi_green += int'(green);
      @(posedge clk); #1;
    end
    check("d40_led_high", 32'(hi_led), 32'd64);
    check("d40_red_high", 32'(hi_red), 32'd0);
    check("d40_green_high", 32'(hi_green), 32'd0);

    // Asynchronous reset mid-operation with a write pending
    access(1'b1, 3'b010, A_LEDS, 32'h00FF_00FF, rd, h);
    repeat (300) @(posedge clk);
    #1;
    access(1'b0, 3'b010, A_LEDS, 32'h0, rd, h);
    check("prereset_leds", rd, 32'h00FF_00FF);
    dmem_wren = 1'b1; funct3 = 3'b010;
    dmem_address = A_LEDS; dmem_data_in = 32'hDEAD_BEEF;
    #2 reset = 1'b1;
    #1;
    check("async_rst_rdata", dmem_data_out, 32'h0);
    check("async_rst_outs", 32'({led, red, green, blue}), 32'h0);
    @(posedge clk); #1;
    check("held_rst_outs", 32'({led, red, green, blue}), 32'h0);
    @(negedge clk);
    dmem_wren = 1'b0;
    reset = 1'b0;
    access(1'b1, 3'b010, A_LEDS, 32'h1122_3344, rd, h);
    check("postrst_leds_clear", rd, 32'h0);
    access(1'b0, 3'b010, A_LEDS, 32'h0, rd, h);
    check("first_write_taken", rd, 32'h1122_3344);
    access(1'b0, 3'b010, A_MICROS, 32'h0, rd, h);
    check("postrst_micros", rd, 32'h0);
    access(1'b0, 3'b010, A_MILLIS, 32'h0, rd, h);
    check("postrst_millis", rd, 32'h0);

    // Timer rates at 12 MHz over 24000 clocks
    do_reset();
    dmem_wren = 1'b0; funct3 = 3'b010; dmem_address = 32'h0;
    repeat (23999) @(posedge clk);
    #1 dmem_address = A_MILLIS;
    @(posedge clk); #1;
    check("millis_at_23999", dmem_data_out, 32'd1);
    @(posedge clk); #1;
    check("millis_at_24000", dmem_data_out, 32'd2);
    dmem_address = A_MICROS;
    @(posedge clk); #1;
    check("micros_at_24001", dmem_data_out, 32'd2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
